// File: rtl/rx_seq_checker.sv
// rx_seq_checker: checks the data_gateway RX stream against an incrementing 32-bit word sequence.
// Latency: one cycle; a word accepted at edge N is reflected in every output after edge N.
// Backpressure: rx_ready is registered from enable and never depends on rx_valid. With
//   CHK_BACKPRESSURE_EN defined, rx_ready is also gated by an LFSR to produce pseudo-random stalls.
//
// Ports:
//   rx_clk, rst          clock; asynchronous active-high reset
//   enable               1 = accept/check, 0 = rx_ready low and state frozen
//   clear                synchronous pulse: zero counters/flags and return to SYNC
//   rx_valid, rx_data    input stream from data_gateway
//   rx_ready             registered accept; transfer = rx_valid & rx_ready
//   locked               1 while the sequence is being tracked
//   word_cnt, err_cnt    saturating counts of accepted and mismatching words
//   err_flag, first_bad  sticky error flag and the data of the first mismatch
//   expected             next expected word
//
// Optional feature macro: CHK_BACKPRESSURE_EN (LFSR-driven rx_ready stalls).

`timescale 1ns/1ps

module rx_seq_checker #(
    parameter int CNT_W     = 32,
    parameter int ERR_LIMIT = 4
`ifdef CHK_BACKPRESSURE_EN
    ,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
    input  logic             rx_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             rx_valid,
    input  logic [31:0]      rx_data,
    output logic             rx_ready,
    output logic             locked,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [31:0]      first_bad,
    output logic [31:0]      expected
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOST  = 2'd2
    } state_t;

    localparam logic [3:0]       MISS_LIM = 4'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic               rx_ready_q, rx_ready_d;
    logic               locked_q, locked_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_flag_q, err_flag_d;
    logic [31:0]        first_bad_q, first_bad_d;
    logic [31:0]        expected_q, expected_d;
    logic [3:0]         miss_q, miss_d;
    logic               xfer;

    assign xfer = rx_valid & rx_ready_q;

`ifdef CHK_BACKPRESSURE_EN
    // Fibonacci LFSR, taps 16,14,13,11. Free-running while enabled; clear does not touch it.
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rx_ready_d = enable & lfsr_q[0];
`else
    assign rx_ready_d = enable;
`endif

    // Next-state and datapath. Transfers are processed even on the cycle enable
    // drops, because rx_ready only falls on the following edge.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_flag_d  = err_flag_q;
        first_bad_d = first_bad_q;
        expected_d  = expected_q;
        miss_d      = miss_q;

        if (clear) begin
            // clear wins over a same-cycle transfer: that word is dropped entirely
            state_d     = ST_SYNC;
            word_cnt_d  = '0;
            err_cnt_d   = '0;
            err_flag_d  = 1'b0;
            first_bad_d = '0;
            expected_d  = '0;
            miss_d      = '0;
        end else if (xfer) begin
            if (word_cnt_q != CNT_MAX) begin
                word_cnt_d = word_cnt_q + CNT_ONE;
            end
            unique case (state_q)
                ST_SYNC: begin
                    expected_d = rx_data + 32'd1;
                    state_d    = ST_TRACK;
                end
                ST_TRACK: begin
                    if (rx_data == expected_q) begin
                        expected_d = expected_q + 32'd1;
                        miss_d     = '0;
                    end else begin
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + CNT_ONE;
                        end
                        if (!err_flag_q) begin
                            err_flag_d  = 1'b1;
                            first_bad_d = rx_data;
                        end
                        // resync to the received word so a single glitch costs one error
                        expected_d = rx_data + 32'd1;
                        miss_d     = miss_q + 4'd1;
                        if (miss_q + 4'd1 >= MISS_LIM) begin
                            state_d = ST_LOST;
                        end
                    end
                end
                ST_LOST: begin
                    expected_d = rx_data + 32'd1;
                    miss_d     = '0;
                    state_d    = ST_TRACK;
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end

        locked_d = (state_d == ST_TRACK);
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            rx_ready_q  <= 1'b0;
            locked_q    <= 1'b0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            first_bad_q <= '0;
            expected_q  <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            locked_q    <= locked_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_flag_q  <= err_flag_d;
            first_bad_q <= first_bad_d;
            expected_q  <= expected_d;
            miss_q      <= miss_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign locked    = locked_q;
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_flag  = err_flag_q;
    assign first_bad = first_bad_q;
    assign expected  = expected_q;

endmodule

// File: tb/tb_rx_seq_checker.sv
// Scoreboard bench for rx_seq_checker: the driver pushes the reference model's
// expected outputs per transfer/clear; a monitor pops and compares after each edge.
`timescale 1ns/1ps

module tb_rx_seq_checker;

    localparam int LIMIT = 4;

    logic        rx_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_ready, locked, err_flag;
    logic [31:0] word_cnt, err_cnt, first_bad, expected;

    rx_seq_checker dut (
        .rx_clk(rx_clk), .rst(rst), .enable(enable), .clear(clear),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .locked(locked), .word_cnt(word_cnt), .err_cnt(err_cnt),
        .err_flag(err_flag), .first_bad(first_bad), .expected(expected)
    );

    always #5 rx_clk = ~rx_clk;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] wc, ec, fb, ex;
        logic        ef, lk;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: sequence rules stated directly in terms of "waiting for a
    // first word", "following the sequence" and "given up after too many misses".
    bit          m_have_ref, m_gave_up, m_ef;
    int          m_misses;
    logic [31:0] m_wc, m_ec, m_fb, m_next;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic void model_reset();
        m_have_ref = 0; m_gave_up = 0; m_ef = 0; m_misses = 0;
        m_wc = 0; m_ec = 0; m_fb = 0; m_next = 0;
    endfunction

    function automatic void model_step(input bit clr, input logic [31:0] w);
        exp_t e;
        if (clr) begin
            model_reset();
        end else begin
            m_wc = sat_inc(m_wc);
            if (!m_have_ref || m_gave_up) begin
                m_have_ref = 1; m_gave_up = 0; m_misses = 0;
            end else if (w != m_next) begin
                m_ec = sat_inc(m_ec);
                if (!m_ef) begin m_ef = 1; m_fb = w; end
                m_misses++;
                if (m_misses == LIMIT) m_gave_up = 1;
            end else begin
                m_misses = 0;
            end
            m_next = w + 32'd1;
        end
        e.wc = m_wc; e.ec = m_ec; e.fb = m_fb; e.ex = m_next;
        e.ef = m_ef; e.lk = m_have_ref && !m_gave_up;
        sb_q.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Drive one word; holds rx_valid until rx_ready, then records the model result.
    task automatic send(input logic [31:0] w, input bit clr = 0);
        bit done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge rx_clk);
            rx_valid = 1'b1; rx_data = w; clear = 1'b0;
            if (rx_ready) begin
                clear = clr;
                model_step(clr, w);
                done = 1;
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: word %h not accepted, rx_ready %b", w, rx_ready);
        end
        @(posedge rx_clk); #1;
        rx_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge rx_clk);
            rx_valid = 1'b0; clear = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(negedge rx_clk);
        rx_valid = 1'b0; clear = 1'b1;
        model_step(1, 32'd0);
        @(posedge rx_clk); #1;
        clear = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_word_cnt"}, word_cnt, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_err_flag"}, 32'(err_flag), 0);
        chk({tag, "_first_bad"}, first_bad, 0);
        chk({tag, "_expected"}, expected, 0);
    endtask

    // Monitor: decides at mid-cycle whether the coming edge is an event, then
    // compares one scoreboard entry just after that edge.
    bit measuring = 0;
    int m_cyc = 0, m_rdy = 0;
    initial begin
        bit ev, en_s, rst_s;
        exp_t e;
        forever begin
            @(negedge rx_clk); #2;
            ev    = !rst && ((rx_valid && rx_ready) || clear);
            en_s  = enable;
            rst_s = rst;
            @(posedge rx_clk); #1;
            if (ev) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL sb_underflow: output event with empty queue at t=%0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("word_cnt", word_cnt, e.wc);
                    chk("err_cnt", err_cnt, e.ec);
                    chk("err_flag", 32'(err_flag), 32'(e.ef));
                    chk("first_bad", first_bad, e.fb);
                    chk("expected", expected, e.ex);
                    chk("locked", 32'(locked), 32'(e.lk));
                end
            end
            if (!rst_s && !rst) begin
`ifdef CHK_BACKPRESSURE_EN
                if (!en_s) chk("rx_ready_off", 32'(rx_ready), 0);
                if (measuring && en_s) begin
                    m_cyc++;
                    if (rx_ready) m_rdy++;
                end
`else
                chk("rx_ready", 32'(rx_ready), 32'(en_s));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit tog_on;
        logic [31:0] base;
        int r;

        model_reset();
        #23;
        chk_all_zero("reset");
        @(negedge rx_clk);
        rst = 1'b0; enable = 1'b1;

        // 1: full-rate incrementing run
        for (int i = 32'h10; i <= 32'h10F; i++) send(32'(i));
        chk("t1_word_cnt", word_cnt, 256);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_expected", expected, 32'h110);
        chk("t1_locked", 32'(locked), 1);

        // 2: wrap across 2^32 is a match
        do_clear();
        send(32'hFFFF_FFFE); send(32'hFFFF_FFFF); send(32'h0); send(32'h1);
        chk("t2_err_cnt", err_cnt, 0);
        chk("t2_err_flag", 32'(err_flag), 0);
        chk("t2_expected", expected, 32'h2);

        // 3: single glitch keeps lock; ERR_LIMIT consecutive misses drop it
        do_clear();
        send(32'h1F); send(32'h20); send(32'h55); send(32'h56);
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_first_bad", first_bad, 32'h55);
        chk("t3_locked", 32'(locked), 1);
        chk("t3_expected", expected, 32'h57);
        send(32'h0); send(32'h9); send(32'h3);
        chk("t3_locked_3miss", 32'(locked), 1);
        send(32'h7);
        chk("t3_lost", 32'(locked), 0);
        send(32'h100); send(32'h101);
        chk("t3_relock", 32'(locked), 1);
        chk("t3_first_bad_kept", first_bad, 32'h55);

        // 4: clear on the same edge as a transfer discards the word
        send(32'h40, 1);
        chk("t4_word_cnt", word_cnt, 0);
        chk("t4_err_flag", 32'(err_flag), 0);
        chk("t4_locked", 32'(locked), 0);
        send(32'h80);
        chk("t4_word_cnt_next", word_cnt, 1);
        chk("t4_expected", expected, 32'h81);

        // 5: enable toggles every 8 cycles while rx_valid stays high
        base = 32'h81;
        tog_on = 1;
        fork
            begin
                for (int i = 0; i < 64; i++) send(base + 32'(i));
                tog_on = 0;
            end
            begin
                int c = 0;
                while (tog_on) begin
                    @(negedge rx_clk);
                    c++;
                    if (c % 8 == 0) enable = ~enable;
                end
            end
        join
        enable = 1'b1;
        chk("t5_word_cnt", word_cnt, 65);
        chk("t5_err_cnt", err_cnt, 0);
        chk("t5_expected", expected, base + 32'd64);

        // randomized mix: mostly in-sequence words, random glitches, gaps, clears, enable drops
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_clear();
            end else if (r < 6) begin
                enable = 1'b0;
                idle($urandom_range(1, 5));
                enable = 1'b1;
            end else if (r < 15) begin
                idle($urandom_range(1, 3));
            end else if (r < 88) begin
                send(m_next);
            end else begin
                send($urandom);
            end
        end

`ifdef CHK_BACKPRESSURE_EN
        // 6: long run under LFSR stalls
        do_clear();
        measuring = 1;
        for (int i = 0; i < 10000; i++) send(32'h1000 + 32'(i));
        measuring = 0;
        chk("t6_err_cnt", err_cnt, 0);
        chk("t6_word_cnt", word_cnt, 10000);
        n_cmp++;
        if (m_cyc == 0 || m_rdy * 100 < m_cyc * 40 || m_rdy * 100 > m_cyc * 60) begin
            n_fail++;
            $display("FAIL t6_duty: ready %0d of %0d enabled cycles, required 40..60%%", m_rdy, m_cyc);
        end
`endif

        // asynchronous reset mid-stream, then recovery from SYNC
        send(32'h3000); send(32'h3001);
        @(negedge rx_clk); #3;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        chk("midrst_sb_empty", 32'(sb_q.size()), 0);
        model_reset();
        @(negedge rx_clk);
        rst = 1'b0;
        send(32'h7777); send(32'h7778);
        chk("rec_word_cnt", word_cnt, 2);
        chk("rec_err_cnt", err_cnt, 0);
        chk("rec_locked", 32'(locked), 1);
        chk("rec_expected", expected, 32'h7779);

        idle(3);
        chk("sb_drain", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
